tinyalu_core: RTL and testbench

//  Synthesizable ALU/scratch-memory target of the start/done command bus driven by the testbench BFM.

---
 rtl/dut_pkg.sv | 33 +++
 rtl/tinyalu_divider.sv | 58 +++++
 rtl/tinyalu_core.sv | 229 ++++++++++++++++++++++
 tb/tb_tinyalu_core.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dut_pkg.sv
// rtl/dut_pkg.sv - opcode, FSM state, error code and latency definitions shared by tinyalu
package dut_pkg;

  typedef enum logic [7:0] {
    OP_NOP = 8'd0,
    OP_ADD = 8'd1,
    OP_AND = 8'd2,
    OP_XOR = 8'd3,
    OP_MUL = 8'd4,
    OP_DIV = 8'd5,
    OP_LDA = 8'd6,
    OP_STA = 8'd7,
    OP_MOV = 8'd8,
    OP_SWP = 8'd9,
    OP_WMR = 8'd10
  } operation_t;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  localparam logic [7:0] ERR_OK      = 8'h00;
  localparam logic [7:0] ERR_DIV0    = 8'h01;
  localparam logic [7:0] ERR_ILLEGAL = 8'h02;
  localparam logic [7:0] ERR_ADDR    = 8'h04;

  localparam int LAT_ALU = 1;
  localparam int LAT_MEM = 2;
  localparam int LAT_SWP = 3;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op >= OP_LDA) && (op <= OP_WMR);
  endfunction

endpackage

// File: rtl/tinyalu_divider.sv
// rtl/tinyalu_divider.sv - unsigned restoring iterative divider, one quotient bit per cycle
module tinyalu_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_rem, r_quo, r_div;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [W:0]    w_shift;
  logic          w_ge;
  logic [W-1:0]  w_sub;

  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_ge    = w_shift >= {1'b0, r_div};
  // remainder stays below the divisor, so the W-bit modular difference is exact
  assign w_sub   = w_shift[W-1:0] - r_div;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
      r_cnt  <= CW'(W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
        r_rem <= w_ge ? w_sub : w_shift[W-1:0];
        r_quo <= {r_quo[W-2:0], w_ge};
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_busy && (r_cnt == '0);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/tinyalu_core.sv
// rtl/tinyalu_core.sv - start/done command ALU with scratch memory, pipelined multiply and iterative divide
module tinyalu_core
  import dut_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 16,
  parameter int MUL_LAT   = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [7:0]          op,
  input  logic                op_prefix,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  output logic                done,
  output logic [2*DATA_W-1:0] result,
  output logic [7:0]          err,
  output logic                gp
);
  localparam int W  = DATA_W;
  localparam int AW = $clog2(MEM_DEPTH);

  state_t         r_state, w_next;
  logic [7:0]     r_op, r_cnt, r_perr;
  logic           r_prefix, r_neg_q, r_neg_r;
  logic [W-1:0]   r_a, r_b, r_tmp;
  logic [2*W-1:0] r_last;
  logic [W-1:0]   r_mem [MEM_DEPTH];
  logic [2*W-1:0] r_mul_pipe [MUL_LAT-1];

  function automatic logic bad_addr(input logic [W-1:0] a);
    return int'(a) >= MEM_DEPTH;
  endfunction

  logic         w_accept, w_illegal, w_bad, w_div0, w_div_start, w_sa, w_sb;
  logic [7:0]   w_perr, w_cnt_init;
  logic [W-1:0] w_mag_a, w_mag_b;

  assign w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_illegal   = op > OP_WMR;
  assign w_bad       = is_mem_op(op) && (bad_addr(A) || ((op == OP_MOV || op == OP_SWP) && bad_addr(B)));
  assign w_div0      = (op == OP_DIV) && (B == '0);
  assign w_div_start = w_accept && (op == OP_DIV) && !w_div0;
  assign w_sa        = op_prefix & A[W-1];
  assign w_sb        = op_prefix & B[W-1];
  assign w_mag_a     = w_sa ? -A : A;
  assign w_mag_b     = w_sb ? -B : B;

  // Error class and execution length are fixed at accept from the live operands.
  always_comb begin
    w_perr     = ERR_OK;
    w_cnt_init = 8'(LAT_ALU - 1);
    if (w_illegal)   w_perr = ERR_ILLEGAL;
    else if (w_bad)  w_perr = ERR_ADDR;
    else if (w_div0) w_perr = ERR_DIV0;
    else begin
      case (op)
        OP_MUL:                         w_cnt_init = 8'(MUL_LAT - 1);
        OP_LDA, OP_STA, OP_MOV, OP_WMR: w_cnt_init = 8'(LAT_MEM - 1);
        OP_SWP:                         w_cnt_init = 8'(LAT_SWP - 1);
        default:                        ;
      endcase
    end
  end

  logic         w_div_busy, w_div_done;
  logic [W-1:0] w_div_q, w_div_r;

  tinyalu_divider #(.W(W)) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (w_div_start),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_div_q),
    .o_remainder(w_div_r)
  );

  logic w_fin;
  assign w_fin = (r_state == ST_EXEC) &&
                 ((r_op == OP_DIV && r_perr == ERR_OK) ? (w_div_busy && w_div_done) : (r_cnt == '0));

  logic [W:0]     w_sum;
  logic [2*W-1:0] w_prod, w_mul_res, w_res;
  logic [W-1:0]   w_q, w_r, w_mem_a, w_mem_b;
  logic           w_gp;

  assign w_sum     = {r_prefix & r_a[W-1], r_a} + {r_prefix & r_b[W-1], r_b};
  assign w_prod    = {{W{r_prefix & r_a[W-1]}}, r_a} * {{W{r_prefix & r_b[W-1]}}, r_b};
  assign w_mul_res = r_mul_pipe[MUL_LAT-2];
  assign w_q       = r_neg_q ? -w_div_q : w_div_q;
  assign w_r       = r_neg_r ? -w_div_r : w_div_r;
  assign w_mem_a   = r_mem[r_a[AW-1:0]];
  assign w_mem_b   = r_mem[r_b[AW-1:0]];

  always_comb begin
    w_res = '0;
    w_gp  = 1'b0;
    if (r_perr == ERR_OK) begin
      case (r_op)
        OP_ADD: begin
          w_res = r_prefix ? {{(W-1){w_sum[W]}}, w_sum} : {{(W-1){1'b0}}, w_sum};
          w_gp  = r_prefix ? (w_sum[W] != w_sum[W-1]) : w_sum[W];
        end
        OP_AND: w_res = {{W{1'b0}}, r_a & r_b};
        OP_XOR: w_res = {{W{1'b0}}, r_a ^ r_b};
        OP_MUL: begin
          w_res = w_mul_res;
          w_gp  = w_mul_res[2*W-1:W] != (r_prefix ? {W{w_mul_res[W-1]}} : {W{1'b0}});
        end
        OP_DIV: begin
          w_res = {w_r, w_q};
          w_gp  = (w_div_r != '0);
        end
        OP_LDA, OP_MOV: w_res = {{W{1'b0}}, w_mem_a};
        OP_STA:         w_res = {{W{1'b0}}, r_b};
        OP_SWP:         w_res = {w_mem_b, r_tmp};
        OP_WMR:         w_res = r_last;
        default:        ;
      endcase
    end
  end

  // Single write port: swap spends its extra cycle writing mem[A] before mem[B].
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [W-1:0]  w_wdata;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_a[AW-1:0];
    w_wdata = r_b;
    if (r_state == ST_EXEC && r_perr == ERR_OK) begin
      case (r_op)
        OP_STA: w_we = (r_cnt == '0);
        OP_MOV: begin
          w_we    = (r_cnt == '0);
          w_waddr = r_b[AW-1:0];
          w_wdata = w_mem_a;
        end
        OP_WMR: begin
          w_we    = (r_cnt == '0);
          w_wdata = r_last[W-1:0];
        end
        OP_SWP: begin
          if (r_cnt == 8'd1) begin
            w_we    = 1'b1;
            w_wdata = w_mem_b;
          end else if (r_cnt == '0) begin
            w_we    = 1'b1;
            w_waddr = r_b[AW-1:0];
            w_wdata = r_tmp;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_EXEC;
      ST_EXEC: if (w_fin) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_EXEC : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign done = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= '0;
      r_prefix <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_perr   <= ERR_OK;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_tmp    <= '0;
      r_last   <= '0;
      result   <= '0;
      err      <= '0;
      gp       <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= op;
        r_prefix <= op_prefix;
        r_a      <= A;
        r_b      <= B;
        r_cnt    <= w_cnt_init;
        r_perr   <= w_perr;
        r_neg_q  <= w_sa ^ w_sb;
        r_neg_r  <= w_sa;
      end else if (r_state == ST_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (r_state == ST_EXEC && r_op == OP_SWP && r_cnt == 8'd1) r_tmp <= w_mem_a;
      if (w_we) r_mem[w_waddr] <= w_wdata;
      if (w_fin) begin
        result <= w_res;
        err    <= r_perr;
        gp     <= w_gp;
        if (r_perr == ERR_OK) r_last <= w_res;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_LAT - 1; i++) r_mul_pipe[i] <= '0;
    end else begin
      r_mul_pipe[0] <= w_prod;
      for (int i = 1; i < MUL_LAT - 1; i++) r_mul_pipe[i] <= r_mul_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_tinyalu_core.sv
// tb/tb_tinyalu_core.sv - directed self-checking bench for tinyalu_core
module tb_tinyalu_core;
  import dut_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, start, op_prefix;
  logic [7:0]  op, A, B;
  logic        done, gp;
  logic [15:0] result;
  logic [7:0]  err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tinyalu_core #(.DATA_W(8), .MEM_DEPTH(16), .MUL_LAT(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .op_prefix(op_prefix),
    .A        (A),
    .B        (B),
    .done     (done),
    .result   (result),
    .err      (err),
    .gp       (gp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] c_op, input logic c_pre,
                         input logic [7:0] c_a, input logic [7:0] c_b, input int exp_lat,
                         input logic [15:0] exp_res, input logic [7:0] exp_err, input logic exp_gp);
    int lat;
    @(negedge clk);
    op = c_op; op_prefix = c_pre; A = c_a; B = c_b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A = ~c_a; B = ~c_b; op_prefix = ~c_pre;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_gp"}, gp, exp_gp);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done, first_k, last_k;
    reset_n = 1'b0; start = 1'b0; op = 8'h00; op_prefix = 1'b0; A = 8'h00; B = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_res", result, 16'h0000);
    chk("rst_err", err, 8'h00);
    chk("rst_gp", gp, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    run_cmd("add_u",   OP_ADD, 1'b0, 8'hFF, 8'h01, 1, 16'h0100, ERR_OK, 1'b1);
    run_cmd("add_s",   OP_ADD, 1'b1, 8'h7F, 8'h01, 1, 16'h0080, ERR_OK, 1'b1);
    run_cmd("mul_s",   OP_MUL, 1'b1, 8'hFD, 8'h05, 3, 16'hFFF1, ERR_OK, 1'b0);
    run_cmd("mul_u",   OP_MUL, 1'b0, 8'h10, 8'h10, 3, 16'h0100, ERR_OK, 1'b1);
    run_cmd("div_u",   OP_DIV, 1'b0, 8'd100, 8'd7, 9, 16'h020E, ERR_OK, 1'b1);
    run_cmd("div_s",   OP_DIV, 1'b1, 8'h9C, 8'd7, 9, 16'hFEF2, ERR_OK, 1'b1);
    run_cmd("div_0",   OP_DIV, 1'b0, 8'd100, 8'd0, 1, 16'h0000, ERR_DIV0, 1'b0);
    run_cmd("sta3",    OP_STA, 1'b0, 8'd3, 8'h5A, 2, 16'h005A, ERR_OK, 1'b0);
    run_cmd("sta4",    OP_STA, 1'b0, 8'd4, 8'hA5, 2, 16'h00A5, ERR_OK, 1'b0);
    run_cmd("swp34",   OP_SWP, 1'b0, 8'd3, 8'd4, 3, 16'hA55A, ERR_OK, 1'b0);
    run_cmd("lda3",    OP_LDA, 1'b0, 8'd3, 8'd0, 2, 16'h00A5, ERR_OK, 1'b0);
    run_cmd("mov45",   OP_MOV, 1'b0, 8'd4, 8'd5, 2, 16'h005A, ERR_OK, 1'b0);
    run_cmd("lda5",    OP_LDA, 1'b0, 8'd5, 8'd0, 2, 16'h005A, ERR_OK, 1'b0);
    run_cmd("and",     OP_AND, 1'b0, 8'hF0, 8'h3C, 1, 16'h0030, ERR_OK, 1'b0);
    run_cmd("wmr6",    OP_WMR, 1'b0, 8'd6, 8'd0, 2, 16'h0030, ERR_OK, 1'b0);
    run_cmd("lda6",    OP_LDA, 1'b0, 8'd6, 8'd0, 2, 16'h0030, ERR_OK, 1'b0);
    run_cmd("swp66",   OP_SWP, 1'b0, 8'd6, 8'd6, 3, 16'h3030, ERR_OK, 1'b0);
    run_cmd("lda6b",   OP_LDA, 1'b0, 8'd6, 8'd0, 2, 16'h0030, ERR_OK, 1'b0);

    @(negedge clk);
    op = OP_XOR; op_prefix = 1'b0; A = 8'h0F; B = 8'hF0; start = 1'b1;
    n_done = 0; first_k = -1; last_k = -1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (k == 8) start = 1'b0;
    end
    chk("b2b_count", n_done, 5);
    chk("b2b_first", first_k, 1);
    chk("b2b_last", last_k, 9);
    chk("b2b_res", result, 16'h00FF);

    run_cmd("illegal", 8'd12, 1'b0, 8'h11, 8'h22, 1, 16'h0000, ERR_ILLEGAL, 1'b0);
    run_cmd("add_pre", OP_ADD, 1'b1, 8'h7F, 8'h01, 1, 16'h0080, ERR_OK, 1'b1);

    @(negedge clk);
    op = OP_DIV; op_prefix = 1'b0; A = 8'd100; B = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_res", result, 16'h0000);
    chk("mid_rst_gp", gp, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("mid_rst_nodone", n_done, 0);

    run_cmd("lda3_clr", OP_LDA, 1'b0, 8'd3, 8'd0, 2, 16'h0000, ERR_OK, 1'b0);
    run_cmd("add_post", OP_ADD, 1'b0, 8'h12, 8'h34, 1, 16'h0046, ERR_OK, 1'b0);
    run_cmd("lda_bad",  OP_LDA, 1'b0, 8'd20, 8'd0, 1, 16'h0000, ERR_ADDR, 1'b0);
    run_cmd("nop",      OP_NOP, 1'b0, 8'h55, 8'hAA, 1, 16'h0000, ERR_OK, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
